// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  localparam int unsigned INSTR_W    = 32;
  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned PC_W       = 32;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DRAIN
  } fetch_state_e;

  // Prefetch entry in the layout latched by the IF/ID buffer.
  typedef struct packed {
    logic [PC_W-1:0]    pc4;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO; clear wins over push and pop, head read from registered storage.
module fetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_clear,
  input  logic [W-1:0]             i_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic [W-1:0]             o_head
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_push = i_push && !i_clear;
  assign w_do_pop  = i_pop && !i_clear && (r_count != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
    end
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: owns the PC, one outstanding imem request, prefetch FIFO toward IF/ID.
// Optional FETCH_PERF_EN adds saturating stall / flush counters.
module if_fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned        DEPTH    = 4,
  parameter int unsigned        ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_rvalid,
  input  logic [31:0]        imem_rdata,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ADDR_W-1:0]  out_pc4,
  output logic [31:0]        out_instr,
  output logic               err_misaligned
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        perf_stall_cycles,
  output logic [31:0]        perf_flush_count
`endif
);

  localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
  localparam int unsigned DATA_W = ADDR_W + INSTR_W;

  fetch_state_e       r_state;
  logic               r_run;
  logic [ADDR_W-1:0]  r_fetch_pc;
  logic [ADDR_W-1:0]  r_req_pc;
  logic               r_err;

  logic [CNT_W-1:0]   w_count;
  logic [DATA_W-1:0]  w_head;
  logic [ADDR_W-1:0]  w_req_pc4;
  logic               w_push;
  logic               w_pop;

  assign w_req_pc4 = r_req_pc + ADDR_W'(WORD_BYTES);
  assign w_push    = (r_state == WAIT) && imem_rvalid && !redirect_valid;
  assign w_pop     = out_valid && out_ready;

  // r_run keeps the strobe quiet through reset and its release cycle.
  assign imem_req  = r_run && (r_state == IDLE) && !redirect_valid &&
                     (w_count < CNT_W'(DEPTH));
  assign imem_addr = r_fetch_pc;

  assign out_valid          = (w_count != '0);
  assign {out_pc4, out_instr} = w_head;
  assign err_misaligned     = r_err;

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (DATA_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_clear (redirect_valid),
    .i_data  ({w_req_pc4, imem_rdata}),
    .o_count (w_count),
    .o_head  (w_head)
  );

  // Fetch FSM; a redirect overrides issue and push, and leaves a stale request to drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_run      <= 1'b0;
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= RESET_PC;
      r_err      <= 1'b0;
    end else begin
      r_run <= 1'b1;
      r_err <= redirect_valid && (redirect_pc[1:0] != 2'b00);
      if (redirect_valid) begin
        r_fetch_pc <= {redirect_pc[ADDR_W-1:2], 2'b00};
        r_state    <= ((r_state != IDLE) && !imem_rvalid) ? DRAIN : IDLE;
      end else begin
        case (r_state)
          IDLE: begin
            if (imem_req) begin
              r_state  <= WAIT;
              r_req_pc <= r_fetch_pc;
            end
          end
          WAIT: begin
            if (imem_rvalid) begin
              r_fetch_pc <= w_req_pc4;
              r_state    <= IDLE;
            end
          end
          DRAIN: begin
            if (imem_rvalid) begin
              r_state <= IDLE;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_flush;

  // Saturating event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_stall <= '0;
      r_perf_flush <= '0;
    end else begin
      if (out_valid && !out_ready && (r_perf_stall != 32'hFFFF_FFFF)) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end
      if (redirect_valid && (r_perf_flush != 32'hFFFF_FFFF)) begin
        r_perf_flush <= r_perf_flush + 32'd1;
      end
    end
  end

  assign perf_stall_cycles = r_perf_stall;
  assign perf_flush_count  = r_perf_flush;
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
// Scoreboard bench for if_fetch_queue: directed fetch/stall/redirect scenarios, 1-cycle memory model.
module tb_if_fetch_queue;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc4;
  logic [31:0] out_instr;
  logic        err_misaligned;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_stall_cycles;
  logic [31:0] perf_flush_count;
`endif

  int unsigned n_cmp = 0;
  int unsigned n_mis = 0;

  fetch_entry_t exp_q[$];
  logic         mem_en;
  logic         pend_valid;
  logic [31:0]  pend_addr;

  if_fetch_queue dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc4        (out_pc4),
    .out_instr      (out_instr),
    .err_misaligned (err_misaligned)
`ifdef FETCH_PERF_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_flush_count  (perf_flush_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return (a == 32'h0) ? 32'h2002_0005 : {16'hC0DE, a[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Memory: records a request at negedge, answers next cycle; mem_en=0 holds the answer.
  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    pend_valid  = 1'b0;
    pend_addr   = '0;
    forever begin
      @(posedge clk);
      #1;
      imem_rvalid = 1'b0;
      if (!rst_n) begin
        pend_valid = 1'b0;
      end else if (mem_en && pend_valid) begin
        pend_valid  = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = word(pend_addr);
      end
      @(negedge clk);
      if (rst_n && imem_req) begin
        pend_valid = 1'b1;
        pend_addr  = imem_addr;
      end
    end
  end

  // Output monitor plus protocol checks.
  always @(negedge clk) begin
    fetch_entry_t e;
    if (rst_n && out_valid && out_ready && !redirect_valid) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_mis++;
        $display("FAIL out_unexpected: got pc4=%h instr=%h expected none", out_pc4, out_instr);
      end else begin
        e = exp_q.pop_front();
        if (out_pc4 !== e.pc4 || out_instr !== e.instr) begin
          n_mis++;
          $display("FAIL out_entry: got pc4=%h instr=%h expected pc4=%h instr=%h",
                   out_pc4, out_instr, e.pc4, e.instr);
        end
      end
    end
    if (rst_n && dut.w_push && (dut.w_count == 3'd4)) begin
      n_mis++;
      $display("FAIL push_when_full: got push with count 4 expected no push");
    end
    if (rst_n && imem_rvalid && (dut.r_state == IDLE)) begin
      n_mis++;
      $display("FAIL rvalid_in_idle: got rvalid in IDLE expected none");
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic drive_tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_req(input string name, input logic [31:0] exp_addr);
    bit found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (imem_req) begin
        found = 1'b1;
        break;
      end
    end
    if (found) check(name, imem_addr, exp_addr);
    else check({name, "_timeout"}, 32'(imem_req), 32'd1);
  endtask

  // Called at a drive point; returns at the drive point after the redirect cycle.
  task automatic redirect(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    exp_q.delete();
    @(negedge clk);
    check("redir_no_req", 32'(imem_req), 32'd0);
    drive_tick();
    redirect_valid = 1'b0;
  endtask

  // Fill to DEPTH with out_ready low from fetch address p, then drain with memory held.
  task automatic fill_drain(input logic [31:0] p);
    fetch_entry_t e;
    for (int k = 0; k < 4; k++) begin
      e.pc4   = p + 32'(4 * (k + 1));
      e.instr = word(p + 32'(4 * k));
      exp_q.push_back(e);
    end
    repeat (14) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check("full_no_req", 32'(imem_req), 32'd0);
      check("full_valid", 32'(out_valid), 32'd1);
      @(negedge clk);
    end
    drive_tick();
    mem_en    = 1'b0;
    out_ready = 1'b1;
    repeat (8) drive_tick();
    out_ready = 1'b0;
    @(negedge clk);
    check("drained_valid", 32'(out_valid), 32'd0);
    check("drained_queue", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    fetch_entry_t e;
    rst_n          = 1'b0;
    mem_en         = 1'b1;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_err", 32'(err_misaligned), 32'd0);
    check("rst_out_pc4", out_pc4, 32'h0);
    check("rst_out_instr", out_instr, 32'h0);
    check("rst_imem_addr", imem_addr, 32'h0);
    drive_tick();
    rst_n = 1'b1;

    // First fetch from address 0, then fill to DEPTH and drain in order
    wait_req("t1_req_addr", 32'h0);
    @(negedge clk);
    check("t1_valid_latency", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("t1_valid", 32'(out_valid), 32'd1);
    check("t1_pc4", out_pc4, 32'h4);
    check("t1_instr", out_instr, 32'h2002_0005);
    fill_drain(32'h0);

    // Redirect during WAIT; stale response 3 cycles later
    drive_tick();
    redirect(32'h40);
    @(negedge clk);
    check("t3_valid", 32'(out_valid), 32'd0);
    check("t3_drain_req", 32'(imem_req), 32'd0);
    drive_tick();
    mem_en = 1'b1;
    @(negedge clk);
    check("t3_drain_req2", 32'(imem_req), 32'd0);
    @(negedge clk);
    check("t3_stale_req", 32'(imem_req), 32'd0);
    @(negedge clk);
    check("t3_req", 32'(imem_req), 32'd1);
    check("t3_addr", imem_addr, 32'h40);
    fill_drain(32'h40);

    // Redirect with a same-cycle response while three entries are buffered
    drive_tick();
    mem_en = 1'b1;
    repeat (12) drive_tick();
    mem_en  = 1'b0;
    e.pc4   = 32'h54;
    e.instr = word(32'h50);
    exp_q.push_back(e);
    out_ready = 1'b1;
    drive_tick();
    out_ready = 1'b0;
    repeat (2) drive_tick();
    mem_en = 1'b1;
    drive_tick();
    redirect(32'h80);
    @(negedge clk);
    mem_en = 1'b0;
    check("t4_valid", 32'(out_valid), 32'd0);
    check("t4_req", 32'(imem_req), 32'd1);
    check("t4_addr", imem_addr, 32'h80);

    // Misaligned redirect
    drive_tick();
    redirect(32'h43);
    @(negedge clk);
    check("t5_err", 32'(err_misaligned), 32'd1);
    check("t5_addr", imem_addr, 32'h40);
    check("t5_no_req", 32'(imem_req), 32'd0);
    @(negedge clk);
    check("t5_err_pulse", 32'(err_misaligned), 32'd0);
    drive_tick();
    mem_en = 1'b1;
    fill_drain(32'h40);

    // PC wrap at the top of the address space
    drive_tick();
    redirect(32'hFFFF_FFFC);
    mem_en = 1'b1;
    wait_req("t6_req_top", 32'hFFFF_FFFC);
    wait_req("t6_req_wrap", 32'h0);
    fill_drain(32'hFFFF_FFFC);

    // Reset mid-transaction with a full FIFO
    drive_tick();
    mem_en = 1'b1;
    repeat (12) drive_tick();
    check("t7_pre_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("t7_rst_valid", 32'(out_valid), 32'd0);
    check("t7_rst_req", 32'(imem_req), 32'd0);
    check("t7_rst_pc4", out_pc4, 32'h0);
    check("t7_rst_addr", imem_addr, 32'h0);
    repeat (2) drive_tick();
    rst_n = 1'b1;

`ifdef FETCH_PERF_EN
    @(negedge clk);
    check("perf_stall_rst", perf_stall_cycles, 32'd0);
    check("perf_flush_rst", perf_flush_count, 32'd0);
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
        if (out_valid) begin
          seen = 1'b1;
          break;
        end
        @(negedge clk);
      end
      check("perf_valid_seen", 32'(seen), 32'd1);
    end
    repeat (5) @(negedge clk);
    check("perf_stall_5", perf_stall_cycles, 32'd5);
    drive_tick();
    redirect(32'h100);
    @(negedge clk);
    check("perf_flush_1", perf_flush_count, 32'd1);
`endif

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
